// File: rtl/scroll_writer_pkg.sv
// Shared definitions for the scrolling seven-segment message writer:
// FSM states, display geometry and the cyclic index helper.
package scroll_writer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      ADVANCE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;  // all segments off (active-low)
   localparam int         MSG_DEPTH = 16;
   localparam int         DIGITS    = 8;

   // Step a message index by one, wrapping to 0 at the message length.
   // Callers keep ptr < len, so a single compare replaces a modulo.
   function automatic logic [3:0] wrap_inc(input logic [3:0] ptr, input logic [4:0] len);
      logic [4:0] nxt;
      nxt = {1'b0, ptr} + 5'd1;
      return (nxt >= len) ? 4'd0 : nxt[3:0];
   endfunction

endpackage

// File: rtl/scroll_writer_tick_gen.sv
// Free-running divider: asserts tick for one cycle every TICK_DIV cycles.
module tick_gen #(
   parameter int TICK_DIV = 25000000
) (
   input  logic Clock,
   input  logic Resetn,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   // Count 0..TICK_DIV-1 continuously; the scroll FSM decides whether to use the tick.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         count <= '0;
      else if (count == LAST)
         count <= '0;
      else
         count <= count + CW'(1);
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/scroll_writer.sv
// Scrolling message writer: on each tick (while run is high) writes eight
// digit patterns to the display stage, leftmost digit first, then advances
// the scroll offset by one character.
module scroll_writer
   import scroll_writer_pkg::*;
#(
   parameter int          TICK_DIV  = 25000000,
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        run,
   input  logic        ld_en,
   input  logic [3:0]  ld_addr,
   input  logic [6:0]  ld_data,
   input  logic [4:0]  msg_len,
   output logic [15:0] ADDR,
   output logic [15:0] data,
   output logic        wren,
   output logic        busy
);

   logic       tick;
   logic [6:0] msg_mem [MSG_DEPTH];

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;        // digit currently presented on the outputs
   logic [4:0]  len_q, len_d;        // message length latched for this burst
   logic [3:0]  offset_q, offset_d;  // message index shown on the leftmost digit
   logic [3:0]  ptr_q, ptr_d;        // message index of the digit on the outputs
   logic [15:0] addr_d, data_d;
   logic        wren_d, busy_d;

   logic [4:0]  len_clamped;
   logic [3:0]  start_off;
   logic [3:0]  ptr_inc;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .Clock  (Clock),
      .Resetn (Resetn),
      .tick   (tick)
   );

   // Message store write port; reads below see the old contents in the write cycle.
   // NOTE: the store has no reset -- clearing a RAM array costs a reset tree and its contents are loaded before use.
   always_ff @(posedge Clock) begin
      if (ld_en)
         msg_mem[ld_addr] <= ld_data;
   end

   assign len_clamped = (msg_len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : msg_len;
   assign start_off   = ({1'b0, offset_q} >= len_clamped) ? 4'd0 : offset_q;
   assign ptr_inc     = wrap_inc(ptr_q, len_q);

   // Next-state and next-output logic; the first digit is prepared on the
   // tick itself so the first write lands one cycle after the tick.
   // NOTE: every signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      offset_d = offset_q;
      ptr_d    = ptr_q;
      addr_d   = ADDR;
      data_d   = data;
      wren_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick && run) begin
               state_d  = BURST;
               idx_d    = '0;
               len_d    = len_clamped;
               offset_d = start_off;
               ptr_d    = start_off;
               wren_d   = 1'b1;
               addr_d   = BASE_ADDR + 16'(DIGITS - 1);
               data_d   = {9'b0, (len_clamped == '0) ? SEG_BLANK : msg_mem[start_off]};
            end
         end
         BURST: begin
            if (idx_q == 3'(DIGITS - 1)) begin
               state_d = ADVANCE;
            end else begin
               idx_d  = idx_q + 3'd1;
               ptr_d  = ptr_inc;
               wren_d = 1'b1;
               addr_d = ADDR - 16'd1;
               data_d = {9'b0, (len_q == '0) ? SEG_BLANK : msg_mem[ptr_inc]};
            end
         end
         ADVANCE: begin
            state_d  = IDLE;
            offset_d = (len_q == '0) ? 4'd0 : wrap_inc(offset_q, len_q);
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   // State and output registers; all module outputs come straight from here.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         offset_q <= '0;
         ptr_q    <= '0;
         ADDR     <= '0;
         data     <= '0;
         wren     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         ptr_q    <= ptr_d;
         ADDR     <= addr_d;
         data     <= data_d;
         wren     <= wren_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_scroll_writer.sv
// Self-checking bench for scroll_writer (TICK_DIV=16, BASE_ADDR=0).
module tb_scroll_writer;

   localparam int          TICK_DIV = 16;
   localparam logic [15:0] BASE     = 16'h0000;

   logic        Clock   = 1'b0;
   logic        Resetn  = 1'b0;
   logic        run     = 1'b0;
   logic        ld_en   = 1'b0;
   logic [3:0]  ld_addr = '0;
   logic [6:0]  ld_data = '0;
   logic [4:0]  msg_len = '0;
   logic [15:0] ADDR;
   logic [15:0] data;
   logic        wren;
   logic        busy;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [6:0] tb_msg [16];
   int         tb_offset = 0;
   int         tb_cnt;
   int         passed = 0;
   int         total  = 0;

   scroll_writer #(
      .TICK_DIV  (TICK_DIV),
      .BASE_ADDR (BASE)
   ) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .run     (run),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .msg_len (msg_len),
      .ADDR    (ADDR),
      .data    (data),
      .wren    (wren),
      .busy    (busy)
   );

   always #5 Clock = ~Clock;

   // Reference tick phase: 0 right after the edge on which a tick is consumed.
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) tb_cnt <= 0;
      else         tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
   end

   task automatic load(input int a, input logic [6:0] v);
      @(negedge Clock);
      ld_en   = 1'b1;
      ld_addr = 4'(a);
      ld_data = v;
      tb_msg[a] = v;
      @(negedge Clock);
      ld_en = 1'b0;
   endtask

   // Scoreboard model of one burst: pushes the 8 expected writes and advances the offset.
   task automatic push_burst(input int len_in);
      int   len, off;
      exp_t e;
      len = (len_in > 16) ? 16 : len_in;
      off = (tb_offset >= len) ? 0 : tb_offset;
      for (int d = 0; d < 8; d++) begin
         e.addr = BASE + 16'(7 - d);
         if (len == 0) e.data = 16'h007F;
         else          e.data = {9'b0, tb_msg[(off + d) % len]};
         exp_q.push_back(e);
      end
      if (len == 0) tb_offset = 0;
      else          tb_offset = (off + 1) % len;
   endtask

   task automatic wait_wren(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (n < 200) begin
         @(negedge Clock);
         n++;
         if (wren === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Resetn = 1'b0;
      repeat (2) @(negedge Clock);
      total++;
      if ({wren, busy} !== 2'b00) $display("FAIL reset_ctrl: wren=%b busy=%b, required 0 0", wren, busy);
      else passed++;
      total++;
      if ({ADDR, data} !== 32'h0) $display("FAIL reset_bus: ADDR=%h data=%h, required 0000 0000", ADDR, data);
      else passed++;
      Resetn = 1'b1;
   endtask

   task automatic test_basic();
      bit   ok;
      int   n;
      exp_t e;
      for (int a = 0; a < 10; a++) load(a, 7'(a + 1));
      msg_len = 5'd10;
      run     = 1'b1;
      for (int b = 0; b < 10; b++) begin
         push_burst(10);
         for (int d = 0; d < 8; d++) begin
            if (d == 0) begin
               wait_wren(ok, n);
               total++;
               if (!ok || tb_cnt != 0) $display("FAIL basic_latency b%0d: wren=%b phase=%0d, required wren=1 phase=0", b, wren, tb_cnt);
               else passed++;
            end else @(negedge Clock);
            e = exp_q.pop_front();
            total++;
            if ({wren, ADDR, data} !== {1'b1, e.addr, e.data})
               $display("FAIL basic b%0d d%0d: wren=%b ADDR=%h data=%h, required 1 %h %h", b, d, wren, ADDR, data, e.addr, e.data);
            else passed++;
         end
      end
      run = 1'b0;
      @(negedge Clock);
      total++;
      if ({wren, busy} !== 2'b01) $display("FAIL basic_advance: wren=%b busy=%b, required 0 1", wren, busy);
      else passed++;
   endtask

   // Table of {msg_len, bursts}: short repeat, offset clear, blank, offset held, clamp.
   task automatic test_lengths();
      int   lens [5] = '{3, 2, 0, 3, 20};
      int   nbs  [5] = '{2, 1, 2, 1, 12};
      bit   ok;
      int   n;
      exp_t e;
      load(0, 7'h11);
      load(1, 7'h22);
      load(2, 7'h33);
      for (int a = 3; a < 16; a++) load(a, 7'(8'h41 + a));
      for (int t = 0; t < 5; t++) begin
         msg_len = 5'(lens[t]);
         run     = 1'b1;
         for (int b = 0; b < nbs[t]; b++) begin
            push_burst(lens[t]);
            for (int d = 0; d < 8; d++) begin
               if (d == 0) begin
                  wait_wren(ok, n);
                  total++;
                  if (!ok || tb_cnt != 0) $display("FAIL len%0d_latency b%0d: wren=%b phase=%0d, required wren=1 phase=0", lens[t], b, wren, tb_cnt);
                  else passed++;
               end else @(negedge Clock);
               e = exp_q.pop_front();
               total++;
               if ({wren, ADDR, data} !== {1'b1, e.addr, e.data})
                  $display("FAIL len%0d b%0d d%0d: wren=%b ADDR=%h data=%h, required 1 %h %h", lens[t], b, d, wren, ADDR, data, e.addr, e.data);
               else passed++;
            end
         end
      end
      run = 1'b0;
   endtask

   task automatic test_run_drop();
      bit   ok;
      int   n, seen;
      exp_t e;
      run = 1'b1;
      for (int b = 0; b < 2; b++) begin
         if (b == 1) begin
            seen = 0;
            repeat (48) begin
               @(negedge Clock);
               if (wren === 1'b1) seen++;
            end
            total++;
            if (seen != 0) $display("FAIL run_drop_idle: %0d writes while paused, required 0", seen);
            else passed++;
            run = 1'b1;
         end
         push_burst(20);
         for (int d = 0; d < 8; d++) begin
            if (d == 0) begin
               wait_wren(ok, n);
               total++;
               if (!ok) $display("FAIL run_drop_start b%0d: wren=%b, required 1", b, wren);
               else passed++;
            end else @(negedge Clock);
            e = exp_q.pop_front();
            total++;
            if ({wren, ADDR, data} !== {1'b1, e.addr, e.data})
               $display("FAIL run_drop b%0d d%0d: wren=%b ADDR=%h data=%h, required 1 %h %h", b, d, wren, ADDR, data, e.addr, e.data);
            else passed++;
            if (d == 2) run = 1'b0;
         end
      end
      run = 1'b0;
   endtask

   // A load to the index read on the same edge returns the old pattern; the new one shows next burst.
   task automatic test_load_collision();
      bit   ok;
      int   n, hit;
      exp_t e;
      hit = (tb_offset + 1) % 16;
      run = 1'b1;
      push_burst(20);
      for (int b = 0; b < 2; b++) begin
         for (int d = 0; d < 8; d++) begin
            if (d == 0) begin
               wait_wren(ok, n);
               total++;
               if (!ok) $display("FAIL collide_start b%0d: wren=%b, required 1", b, wren);
               else passed++;
            end else @(negedge Clock);
            e = exp_q.pop_front();
            total++;
            if ({wren, ADDR, data} !== {1'b1, e.addr, e.data})
               $display("FAIL collide b%0d d%0d: wren=%b ADDR=%h data=%h, required 1 %h %h", b, d, wren, ADDR, data, e.addr, e.data);
            else passed++;
            if (b == 0 && d == 0) begin
               ld_en   = 1'b1;
               ld_addr = 4'(hit);
               ld_data = 7'h55;
            end
            if (b == 0 && d == 1) begin
               ld_en = 1'b0;
               tb_msg[hit] = 7'h55;
            end
         end
         if (b == 0) push_burst(20);
      end
      run = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      bit   ok;
      int   n;
      exp_t e;
      run = 1'b1;
      wait_wren(ok, n);
      repeat (3) @(negedge Clock);
      total++;
      if (!ok || wren !== 1'b1) $display("FAIL rst_mid_pre: wren=%b, required 1 at 4th write", wren);
      else passed++;
      Resetn = 1'b0;
      #1;
      total++;
      if ({wren, busy, ADDR, data} !== 34'h0)
         $display("FAIL rst_mid_abort: wren=%b busy=%b ADDR=%h data=%h, required all 0", wren, busy, ADDR, data);
      else passed++;
      tb_offset = 0;
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
      push_burst(20);
      for (int d = 0; d < 8; d++) begin
         if (d == 0) begin
            wait_wren(ok, n);
            total++;
            if (!ok || n != TICK_DIV) $display("FAIL rst_mid_latency: first write after %0d cycles, required %0d", n, TICK_DIV);
            else passed++;
         end else @(negedge Clock);
         e = exp_q.pop_front();
         total++;
         if ({wren, ADDR, data} !== {1'b1, e.addr, e.data})
            $display("FAIL rst_mid d%0d: wren=%b ADDR=%h data=%h, required 1 %h %h", d, wren, ADDR, data, e.addr, e.data);
         else passed++;
      end
      run = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_lengths();
      test_run_drop();
      test_load_collision();
      test_reset_mid_burst();
      total++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
